// File: rtl/frame_pkg.sv
// frame_pkg: shared framing constants, FSM state type and the CRC16-CCITT step
package frame_pkg;
  localparam logic [15:0] HEADER_WORD = 16'hE0E0;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam int MAX_WORDS = 8;
  typedef enum logic [2:0] {IDLE, HEAD, CTRL, PAY, CRC, GAP} state_e;
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/frame_crc16.sv
// frame_crc16: registered CRC16 accumulator; init reseeds, step folds in din, otherwise holds
module frame_crc16 #(
  parameter logic [15:0] INIT = frame_pkg::CRC_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        step,
  input  logic [15:0] din,
  output logic [15:0] crc_q,
  output logic [15:0] crc_d
);
  import frame_pkg::*;
  always_comb crc_d = init ? INIT : step ? crc16_step(crc_q, din) : crc_q;
  always_ff @(posedge clk) crc_q <= rst ? INIT : crc_d;
endmodule

// File: rtl/frame_generator.sv
// frame_generator: serialises descriptors into header, control, payload and CRC16 words with registered outputs
module frame_generator #(
  parameter logic [15:0] HEADER = frame_pkg::HEADER_WORD,
  parameter logic [15:0] IDLE_WORD = 16'h0000,
  parameter logic [15:0] CRC_INIT = frame_pkg::CRC_INIT,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_WORDS = frame_pkg::MAX_WORDS
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         frm_valid,
  output logic         frm_ready,
  input  logic [7:0]   frm_vld_ch,
  input  logic [3:0]   frm_len,
  input  logic [127:0] frm_data,
  input  logic         crc_corrupt,
  output logic [15:0]  data_out,
  output logic         data_out_vld,
  output logic         frame_start,
  output logic         frame_end,
  output logic         busy
);
  import frame_pkg::*;
  state_e state_q, state_d;
  logic [7:0] vld_ch_q, vld_ch_d;
  logic [3:0] len_q, len_d, idx_q, idx_d, gap_q, gap_d;
  logic [127:0] data_q, data_d, pay_sh;
  logic corrupt_q, corrupt_d, accept, step;
  logic [15:0] data_out_q, data_out_d, crc_q, crc_d;
  logic vld_q, vld_d, start_q, start_d, end_q, end_d, busy_q, busy_d, ready_q, ready_d;
  assign accept = state_q == IDLE && ready_q && frm_valid;
  assign step = state_q == CTRL || state_q == PAY;
  frame_crc16 #(.INIT(CRC_INIT)) u_crc (
    .clk(clk_in), .rst(rst), .init(accept), .step(step), .din(data_out_q), .crc_q(crc_q), .crc_d(crc_d)
  );
  always_comb begin
    state_d = state_q;
    vld_ch_d = vld_ch_q;
    len_d = len_q;
    data_d = data_q;
    corrupt_d = corrupt_q;
    idx_d = idx_q;
    gap_d = gap_q;
    case (state_q)
      IDLE: if (accept) begin
        vld_ch_d = frm_vld_ch;
        len_d = frm_len > 4'(MAX_WORDS) ? 4'(MAX_WORDS) : frm_len;
        data_d = frm_data;
        corrupt_d = crc_corrupt;
        state_d = HEAD;
      end
      HEAD: state_d = CTRL;
      CTRL: begin
        idx_d = '0;
        state_d = len_q != '0 ? PAY : CRC;
      end
      PAY: begin
        idx_d = idx_q + 4'd1;
        state_d = idx_q == len_q - 4'd1 ? CRC : PAY;
      end
      CRC: begin
        gap_d = '0;
        state_d = GAP_CYCLES > 0 ? GAP : IDLE;
      end
      GAP: begin
        gap_d = gap_q + 4'd1;
        state_d = gap_q == 4'(GAP_CYCLES - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are computed for the state being entered
    pay_sh = data_q << {idx_d, 4'b0000};
    data_out_d = state_d == HEAD ? HEADER :
                 state_d == CTRL ? {vld_ch_q, 4'h0, len_q} :
                 state_d == PAY ? pay_sh[127:112] :
                 state_d == CRC ? crc_d ^ {15'b0, corrupt_q} : IDLE_WORD;
    vld_d = state_d inside {HEAD, CTRL, PAY, CRC};
    start_d = state_d == HEAD;
    end_d = state_d == CRC;
    busy_d = state_d != IDLE;
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      vld_ch_q <= '0;
      len_q <= '0;
      data_q <= '0;
      corrupt_q <= 1'b0;
      idx_q <= '0;
      gap_q <= '0;
      data_out_q <= IDLE_WORD;
      vld_q <= 1'b0;
      start_q <= 1'b0;
      end_q <= 1'b0;
      busy_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_ch_q <= vld_ch_d;
      len_q <= len_d;
      data_q <= data_d;
      corrupt_q <= corrupt_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
      data_out_q <= data_out_d;
      vld_q <= vld_d;
      start_q <= start_d;
      end_q <= end_d;
      busy_q <= busy_d;
      ready_q <= ready_d;
    end
  end
  assign data_out = data_out_q;
  assign data_out_vld = vld_q;
  assign frame_start = start_q;
  assign frame_end = end_q;
  assign busy = busy_q;
  assign frm_ready = ready_q;
endmodule

// File: tb/tb_frame_generator.sv
// tb_frame_generator: directed table-driven checks of frame_generator word stream, CRC and handshake timing
module tb_frame_generator;
  logic clk_in = 1'b0, rst = 1'b1, frm_valid = 1'b0, crc_corrupt = 1'b0;
  logic frm_ready, data_out_vld, frame_start, frame_end, busy;
  logic [7:0] frm_vld_ch = '0;
  logic [3:0] frm_len = '0;
  logic [127:0] frm_data = '0;
  logic [15:0] data_out;
  int total = 0, passed = 0, cyc = 0, acc_n = 0, rb_err = 0;
  int acc_t [2];
  logic arm = 1'b0;
  frame_generator dut (
    .clk_in(clk_in), .rst(rst), .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_vld_ch(frm_vld_ch),
    .frm_len(frm_len), .frm_data(frm_data), .crc_corrupt(crc_corrupt), .data_out(data_out),
    .data_out_vld(data_out_vld), .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    cyc++;
    if (frm_ready && busy) rb_err++;
    if (arm && frm_valid && frm_ready && acc_n < 2) begin
      acc_t[acc_n] = cyc;
      acc_n++;
    end
  end
  typedef struct {
    logic [7:0] ch;
    logic [3:0] len;
    logic [127:0] data;
    logic corrupt;
    logic [15:0] exp_ctrl;
    int exp_words;
  } vec_t;
  vec_t vt [6];
  logic [15:0] crcs [6], res [6];
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 16; i++) begin
      fb = r[15] ^ d[15 - i];
      r = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask
  task automatic flags(input string nm, input logic [4:0] exp);
    chk(nm, {27'b0, data_out_vld, frame_start, frame_end, busy, frm_ready}, {27'b0, exp});
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!frm_ready && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    chk("ready_wait", {31'b0, frm_ready}, 1);
  endtask
  task automatic drive(input vec_t v);
    frm_vld_ch = v.ch;
    frm_len = v.len;
    frm_data = v.data;
    crc_corrupt = v.corrupt;
    frm_valid = 1'b1;
  endtask
  task automatic scramble();
    frm_valid = 1'b0;
    frm_vld_ch = ~frm_vld_ch;
    frm_len = 4'h3;
    frm_data = ~frm_data;
    crc_corrupt = ~crc_corrupt;
  endtask
  task automatic send(input int id, input vec_t v, output logic [15:0] crc_w, output logic [15:0] rs);
    logic [15:0] c, exp;
    logic [127:0] sh;
    wait_ready();
    drive(v);
    @(negedge clk_in);
    scramble();
    c = 16'hFFFF;
    sh = v.data;
    crc_w = '0;
    for (int k = 0; k < v.exp_words; k++) begin
      if (k == 0) exp = 16'hE0E0;
      else if (k == 1) exp = v.exp_ctrl;
      else if (k == v.exp_words - 1) exp = c ^ {15'b0, v.corrupt};
      else begin
        exp = sh[127:112];
        sh = sh << 16;
      end
      chk($sformatf("v%0d_word%0d", id, k), {16'b0, data_out}, {16'b0, exp});
      flags($sformatf("v%0d_flags%0d", id, k), {1'b1, k == 0, k == v.exp_words - 1, 1'b1, 1'b0});
      if (k >= 1 && k < v.exp_words - 1) c = ref_crc(c, exp);
      if (k == v.exp_words - 1) crc_w = data_out;
      @(negedge clk_in);
    end
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("v%0d_gap_data%0d", id, g), {16'b0, data_out}, 0);
      flags($sformatf("v%0d_gap_flags%0d", id, g), 5'b00010);
      @(negedge clk_in);
    end
    flags($sformatf("v%0d_idle_flags", id), 5'b00001);
    rs = ref_crc(c, crc_w);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] cw, rr;
    vt[0] = '{8'h03, 4'd2, {32'h1234_5678, 96'h0}, 1'b0, 16'h0302, 5};
    vt[1] = '{8'hFF, 4'd0, 128'h0, 1'b0, 16'hFF00, 3};
    vt[2] = '{8'hA5, 4'hF, 128'h0001_0002_0003_0004_0005_0006_0007_0008, 1'b0, 16'hA508, 11};
    vt[3] = '{8'h03, 4'd2, {32'h1234_5678, 96'h0}, 1'b1, 16'h0302, 5};
    vt[4] = '{8'h5A, 4'd8, 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF, 1'b0, 16'h5A08, 11};
    vt[5] = '{8'h81, 4'd1, 128'hA5A5_0000_0000_0000_0000_0000_0000_FFFF, 1'b0, 16'h8101, 4};
    repeat (3) @(negedge clk_in);
    chk("reset_data", {16'b0, data_out}, 0);
    flags("reset_flags", 5'b00000);
    rst = 1'b0;
    @(negedge clk_in);
    flags("ready_after_reset", 5'b00001);
    for (int i = 0; i < 6; i++) begin
      send(i, vt[i], cw, rr);
      crcs[i] = cw;
      res[i] = rr;
      if (!vt[i].corrupt) chk($sformatf("v%0d_residue", i), {16'b0, res[i]}, 0);
    end
    chk("corrupt_bit0_only", {16'b0, crcs[0] ^ crcs[3]}, 1);
    chk("corrupt_residue_nonzero", {31'b0, res[3] != 16'h0}, 1);
    wait_ready();
    arm = 1'b1;
    drive(vt[0]);
    for (int n = 0; acc_n < 2 && n < 60; n++) @(negedge clk_in);
    frm_valid = 1'b0;
    chk("two_accepts", acc_n, 2);
    chk("accept_spacing", acc_t[1] - acc_t[0], 8);
    wait_ready();
    drive(vt[2]);
    @(negedge clk_in);
    scramble();
    repeat (3) @(negedge clk_in);
    chk("pay_before_reset_vld", {31'b0, data_out_vld}, 1);
    rst = 1'b1;
    @(negedge clk_in);
    chk("midreset_data", {16'b0, data_out}, 0);
    flags("midreset_flags", 5'b00000);
    rst = 1'b0;
    @(negedge clk_in);
    flags("midreset_release", 5'b00001);
    send(6, vt[4], cw, rr);
    chk("after_reset_residue", {16'b0, rr}, 0);
    chk("no_ready_while_busy", rb_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
